// File: rtl/xilinx_fifo_rd_stream_if.sv
// FIFO read-port plus valid/ready stream bundle for xilinx_fifo_rd_stream.
// RD_WORDS exists only when XILINX_FIFO_RD_STREAM_STATS_EN is defined.
interface xilinx_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 36,
  parameter int BUF_DEPTH  = 4
);
  localparam int LW = $clog2(BUF_DEPTH) + 1;

  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_DO;
  logic                  FIFO_RDERR;
  logic                  FIFO_RDEN;
  logic                  M_VALID;
  logic                  M_READY;
  logic [DATA_WIDTH-1:0] M_DATA;
  logic [LW-1:0]         M_LEVEL;
  logic                  RDERR_STICKY;
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
  logic [31:0]           RD_WORDS;
`endif

  modport master (
    input  FIFO_EMPTY, FIFO_DO, FIFO_RDERR, M_READY,
    output FIFO_RDEN, M_VALID, M_DATA, M_LEVEL, RDERR_STICKY
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
    , output RD_WORDS
`endif
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DO, FIFO_RDERR, M_READY,
    input  FIFO_RDEN, M_VALID, M_DATA, M_LEVEL, RDERR_STICKY
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
    , input RD_WORDS
`endif
  );
endinterface

// File: rtl/xilinx_fifo_rd_stream.sv
// Standard-mode BRAM FIFO read port to valid/ready stream; XILINX_FIFO_RD_STREAM_STATS_EN adds RD_WORDS.
// Latency: RDEN in cycle n -> M_VALID in cycle n+RD_LATENCY+1.
// Backpressure: reads are credit-limited by buffer space, so M_READY low never drops in-flight words.
module xilinx_fifo_rd_stream #(
  parameter int DATA_WIDTH = 36,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input logic                     RDCLK,
  input logic                     RSTN,
  xilinx_fifo_rd_stream_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = LW + 1;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [RD_LATENCY-1:0] infl;
  logic [RD_LATENCY-1:0] infl_nxt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         occ;
  logic [CW-1:0]         credit_used;
  logic                  rden;
  logic                  push;
  logic                  pop;
  logic                  rderr_sticky;
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
  logic [31:0]           rd_words;
`endif

  // Credits count both buffered words and reads whose data is still in the FIFO pipeline.
  always_comb begin
    credit_used = CW'(occ);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + CW'(infl[i]);
    end
    rden = !bus.FIFO_EMPTY && (credit_used < CW'(BUF_DEPTH));
    infl_nxt    = '0;
    infl_nxt[0] = rden;
    for (int i = 1; i < RD_LATENCY; i++) begin
      infl_nxt[i] = infl[i-1];
    end
    push = infl[RD_LATENCY-1];
    pop  = (occ != '0) && bus.M_READY;
  end

  always_ff @(posedge RDCLK) begin
    if (!RSTN) begin
      infl         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      rderr_sticky <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
      rd_words     <= '0;
`endif
    end else begin
      infl <= infl_nxt;
      if (push) begin
        mem[wr_ptr] <= bus.FIFO_DO;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        occ <= occ + LW'(1);
      end else if (pop && !push) begin
        occ <= occ - LW'(1);
      end
      if (bus.FIFO_RDERR) begin
        rderr_sticky <= 1'b1;
      end
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
      if (pop) begin
        rd_words <= rd_words + 32'd1;
      end
`endif
    end
  end

  assign bus.FIFO_RDEN    = rden;
  assign bus.M_VALID      = (occ != '0);
  assign bus.M_DATA       = mem[rd_ptr];
  assign bus.M_LEVEL      = occ;
  assign bus.RDERR_STICKY = rderr_sticky;
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
  assign bus.RD_WORDS     = rd_words;
`endif
endmodule

// File: tb/tb_xilinx_fifo_rd_stream.sv
// Bench for xilinx_fifo_rd_stream: behavioural standard-mode FIFO plus an in-order word scoreboard.
module tb_xilinx_fifo_rd_stream;
  localparam int DW = 36;
  localparam int RL = 2;
  localparam int BD = 4;
  localparam int LW = $clog2(BD) + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xilinx_fifo_rd_stream_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();

  xilinx_fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(RL), .BUF_DEPTH(BD)) dut (
    .RDCLK (clk),
    .RSTN  (rstn),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int issued = 0;
  int delivered = 0;
  int bad_rden = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stage1 = '0;

  logic          obs_rden = 1'b0;
  logic          obs_vld  = 1'b0;
  logic          obs_rdy  = 1'b0;
  logic          obs_hs   = 1'b0;
  logic [DW-1:0] obs_dat;
  logic [LW-1:0] obs_lvl;
  logic          obs_err;

  // One clock: FIFO model reacts to the RDEN of the cycle just ended, then new inputs, then sample.
  task automatic tick(input logic rdy, input logic force_empty);
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    cyc++;
    if (!rstn) begin
      fq.delete();
      exp_q.delete();
      stage1 = '0;
      bus.FIFO_DO = '0;
      issued = 0;
      delivered = 0;
    end else begin
      if (obs_hs) delivered++;
      if (RL == 2) bus.FIFO_DO = stage1;
      if (obs_rden === 1'b1) begin
        issued++;
        if (fq.size() == 0) begin
          bad_rden++;
        end else begin
          w = fq.pop_front();
          if (RL == 2) stage1 = w;
          else bus.FIFO_DO = w;
        end
      end
    end
    bus.M_READY    = rdy;
    bus.FIFO_EMPTY = (fq.size() == 0) || force_empty;
    @(negedge clk);
    obs_rden = bus.FIFO_RDEN;
    obs_vld  = bus.M_VALID;
    obs_rdy  = bus.M_READY;
    obs_hs   = (obs_vld === 1'b1) && (obs_rdy === 1'b1);
    obs_dat  = bus.M_DATA;
    obs_lvl  = bus.M_LEVEL;
    obs_err  = bus.RDERR_STICKY;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    n_vec++;
    if ({obs_rden, obs_vld, obs_lvl, obs_err} !== '0 || obs_dat !== '0) begin
      n_err++;
      $display("FAIL reset_state: rden=%b vld=%b lvl=%0d err=%b dat=%h, required all 0",
               obs_rden, obs_vld, obs_lvl, obs_err, obs_dat);
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1);
      n_vec++;
      if ({obs_rden, obs_vld, obs_lvl, obs_err} !== '0) begin
        n_err++;
        $display("FAIL idle_c%0d: rden=%b vld=%b lvl=%0d err=%b, required all 0",
                 i, obs_rden, obs_vld, obs_lvl, obs_err);
      end
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] exp_w;
    int n_rd = -1;
    int n_v = -1;
    int rd_cnt = 0;
    fq.push_back(DW'(8'hA5));
    exp_q.push_back(DW'(8'hA5));
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (obs_rden === 1'b1) begin
        rd_cnt++;
        if (n_rd < 0) n_rd = cyc;
      end
      if (obs_vld === 1'b1 && n_v < 0) n_v = cyc;
      if (obs_hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL latency_extra: got %h, required no word", obs_dat);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_dat !== exp_w) begin
            n_err++;
            $display("FAIL latency_data: got %h, required %h", obs_dat, exp_w);
          end
        end
      end
    end
    n_vec++;
    if (rd_cnt != 1) begin
      n_err++;
      $display("FAIL latency_rden_count: got %0d, required 1", rd_cnt);
    end
    n_vec++;
    if (n_rd < 0 || n_v - n_rd != RL + 1) begin
      n_err++;
      $display("FAIL latency_cycles: rden@%0d valid@%0d, required distance %0d", n_rd, n_v, RL + 1);
    end
    n_vec++;
    if (exp_q.size() != 0 || bad_rden != 0) begin
      n_err++;
      $display("FAIL latency_drain: left=%0d bad_rden=%0d, required 0 and 0", exp_q.size(), bad_rden);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_w;
    int got = 0;
    bit started = 0;
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
    logic [31:0] words0 = bus.RD_WORDS;
`endif
    for (int i = 0; i < 100; i++) begin
      fq.push_back(DW'(i));
      exp_q.push_back(DW'(i));
    end
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, 1'b0);
      if (obs_vld === 1'b1) started = 1;
      if (started && got < 100) begin
        n_vec++;
        if (obs_vld !== 1'b1) begin
          n_err++;
          $display("FAIL stream_bubble: M_VALID=%b after %0d words, required 1", obs_vld, got);
        end
      end
      if (obs_hs) begin
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra: got %h, required no word", obs_dat);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_dat !== exp_w) begin
            n_err++;
            $display("FAIL stream_data: got %h, required %h", obs_dat, exp_w);
          end
        end
      end
    end
    n_vec++;
    if (got != 100) begin
      n_err++;
      $display("FAIL stream_count: got %0d words, required 100", got);
    end
`ifdef XILINX_FIFO_RD_STREAM_STATS_EN
    n_vec++;
    if (bus.RD_WORDS - words0 !== 32'd100) begin
      n_err++;
      $display("FAIL stream_rd_words: delta %0d, required 100", bus.RD_WORDS - words0);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_w;
    logic [DW-1:0] held = '0;
    bit have = 0;
    int rd_cnt = 0;
    int got = 0;
    for (int i = 0; i < 10; i++) begin
      fq.push_back(DW'(256 + i));
      exp_q.push_back(DW'(256 + i));
    end
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b0);
      if (obs_rden === 1'b1) rd_cnt++;
      if (obs_vld === 1'b1) begin
        if (!have) begin
          held = obs_dat;
          have = 1;
        end else begin
          n_vec++;
          if (obs_dat !== held) begin
            n_err++;
            $display("FAIL bp_stable: M_DATA %h changed, required %h", obs_dat, held);
          end
        end
      end
    end
    n_vec++;
    if (rd_cnt != BD) begin
      n_err++;
      $display("FAIL bp_rden_count: got %0d pulses, required %0d", rd_cnt, BD);
    end
    n_vec++;
    if (obs_lvl !== LW'(BD)) begin
      n_err++;
      $display("FAIL bp_level: got %0d, required %0d", obs_lvl, BD);
    end
    n_vec++;
    if (!have || held !== DW'(256)) begin
      n_err++;
      $display("FAIL bp_head: got %h, required %h", held, DW'(256));
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      if (obs_hs) begin
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: got %h, required no word", obs_dat);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_dat !== exp_w) begin
            n_err++;
            $display("FAIL bp_data: got %h, required %h", obs_dat, exp_w);
          end
        end
      end
    end
    n_vec++;
    if (got != 10) begin
      n_err++;
      $display("FAIL bp_count: got %0d words, required 10", got);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_w;
    logic [DW-1:0] w;
    for (int i = 0; i < 1500; i++) begin
      w = DW'({$urandom(), $urandom()});
      fq.push_back(w);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 5400; i++) begin
      if (i < 5000) tick(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30));
      else          tick(1'b1, 1'b0);
      n_vec++;
      if (issued - delivered > BD) begin
        n_err++;
        $display("FAIL rand_credit: outstanding %0d at cycle %0d, required <= %0d",
                 issued - delivered, cyc, BD);
      end
      if (obs_hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: got %h, required no word", obs_dat);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_dat !== exp_w) begin
            n_err++;
            $display("FAIL rand_data: got %h, required %h", obs_dat, exp_w);
          end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0 || bad_rden != 0) begin
      n_err++;
      $display("FAIL rand_drain: left=%0d bad_rden=%0d, required 0 and 0", exp_q.size(), bad_rden);
    end
  endtask

  task automatic test_error_reset();
    for (int i = 0; i < 5; i++) begin
      fq.push_back(DW'(512 + i));
      exp_q.push_back(DW'(512 + i));
    end
    bus.FIFO_RDERR = 1'b1;
    tick(1'b0, 1'b0);
    bus.FIFO_RDERR = 1'b0;
    n_vec++;
    if (obs_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: RDERR_STICKY=%b, required 1", obs_err);
    end
    tick(1'b0, 1'b0);
    n_vec++;
    if (obs_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_hold: RDERR_STICKY=%b, required 1", obs_err);
    end
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if ({obs_rden, obs_vld, obs_lvl, obs_err} !== '0 || obs_dat !== '0) begin
        n_err++;
        $display("FAIL rst_mid_c%0d: rden=%b vld=%b lvl=%0d err=%b dat=%h, required all 0",
                 i, obs_rden, obs_vld, obs_lvl, obs_err, obs_dat);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (obs_vld !== 1'b0 || obs_rden !== 1'b0 || obs_err !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale_c%0d: vld=%b rden=%b err=%b dat=%h, required 0 0 0",
                 i, obs_vld, obs_rden, obs_err, obs_dat);
      end
    end
  endtask

  initial begin
    rstn           = 1'b0;
    bus.FIFO_EMPTY = 1'b1;
    bus.FIFO_DO    = '0;
    bus.FIFO_RDERR = 1'b0;
    bus.M_READY    = 1'b0;
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_random();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xilinx_fifo_rd_stream.md
Name: xilinx_fifo_rd_stream

Overview:
Read-side consumer for the dual-clock 7-series BRAM FIFO wrapper. Runs in the FIFO read clock domain and drives the FIFO's RDEN. Turns the standard-mode (non-FWFT, fixed read latency) FIFO read port into a valid/ready stream. A small credit-managed output buffer sustains one word per cycle under back-pressure without losing in-flight reads.

Parameters:
DATA_WIDTH, 36, width of FIFO_DO and M_DATA (1-72).
RD_LATENCY, 2, cycles from RDEN sample to data on FIFO_DO: 2 when the FIFO's DO_REG=1, 1 when DO_REG=0. Legal values are 1 and 2.
BUF_DEPTH, 4, output buffer entries; power of 2, minimum RD_LATENCY+2 (full throughput needs exactly this minimum).

Ports:
RDCLK  in  1  read-domain clock; all logic on the rising edge
RSTN  in  1  synchronous reset, active-low
FIFO_EMPTY  in  1  EMPTY from the FIFO
FIFO_DO  in  DATA_WIDTH  DO from the FIFO
FIFO_RDERR  in  1  RDERR from the FIFO
FIFO_RDEN  out  1  RDEN to the FIFO
M_VALID  out  1  stream word available
M_READY  in  1  downstream accepts the word
M_DATA  out  DATA_WIDTH  stream data
M_LEVEL  out  $clog2(BUF_DEPTH)+1  current buffer occupancy
RDERR_STICKY  out  1  FIFO reported a read error since reset

Behaviour:
- Reset (RSTN=0 at an edge): FIFO_RDEN=0, M_VALID=0, M_DATA=0, M_LEVEL=0, RDERR_STICKY=0. In-flight shift register, pointers and occupancy are cleared.
- Reset mid-operation: in-flight reads are discarded. System rule: the FIFO RST must be asserted whenever RSTN is asserted.
- State:
  - occ: buffer occupancy.
  - infl: RD_LATENCY-bit shift register of issued reads.
  - wr_ptr, rd_ptr: log2(BUF_DEPTH)-bit pointers that wrap modulo BUF_DEPTH.
- Issue rule: FIFO_RDEN = !FIFO_EMPTY && (occ + popcount(infl)) < BUF_DEPTH.
  - Computed only from registered state and FIFO_EMPTY.
  - No combinational path from M_READY to FIFO_RDEN.
- Each cycle: infl shifts in FIFO_RDEN. When the bit shifting out (the oldest) is 1, FIFO_DO is written to buf[wr_ptr] and wr_ptr increments.
- Latency: RDEN high in cycle n -> data captured at end of cycle n+RD_LATENCY -> M_VALID=1 in cycle n+RD_LATENCY+1.
- Stream side:
  - M_VALID = (occ != 0); M_DATA = buf[rd_ptr].
  - Pop on M_VALID && M_READY: rd_ptr increments.
  - M_DATA and M_VALID must stay stable while M_VALID && !M_READY.
- Simultaneous push and pop: occ is unchanged and both pointers advance. Push on an empty buffer with no pop: occ goes 0->1.
- Credit invariant: occ + popcount(infl) <= BUF_DEPTH. Overflow is impossible by construction; the bench asserts the invariant.
- Throughput: with BUF_DEPTH >= RD_LATENCY+2 and M_READY held high, the block delivers one word per cycle in steady state.
- FIFO_EMPTY: ignored by design whenever the issue rule is false. RDEN is never driven while FIFO_EMPTY=1, so FIFO_RDERR is not expected.
- FIFO_RDERR=1 in any cycle sets RDERR_STICKY; only reset clears it.
- M_LEVEL = occ (registered).

Optional Feature:
Macro XILINX_FIFO_RD_STREAM_STATS_EN.
- Defined: adds output RD_WORDS [31:0], a free-running count of stream handshakes (M_VALID && M_READY).
  - Reset value 0; wraps from 0xFFFFFFFF to 0.
  - Increments by exactly 1 per handshake.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: RSTN=0 for 3 cycles, then FIFO_EMPTY=1 for 20 cycles -> FIFO_RDEN, M_VALID, M_LEVEL and RDERR_STICKY all stay 0.
- Latency check (RD_LATENCY=2): FIFO model holds 1 word 0xA5, M_READY=1 -> RDEN high for cycle n only, M_VALID=1 in cycle n+3 with M_DATA=0xA5, popped the same cycle.
- Streaming: 100 words 0..99 preloaded, M_READY=1 -> after the initial latency, 100 consecutive M_VALID cycles with data 0..99 in order and no bubbles.
- Back-pressure: 10 words preloaded, M_READY=0 -> RDEN pulses exactly 4 times, M_LEVEL settles at 4, and M_DATA holds word 0 stably. Then M_READY=1 -> words 0..9 delivered in order, with no loss or duplication.
- Random: random M_READY (50%) and random FIFO_EMPTY over 5000 cycles -> output sequence equals input sequence and the credit invariant never fails.
- Error/reset: inject FIFO_RDERR=1 for one cycle -> RDERR_STICKY=1 and held. Then assert RSTN=0 with 2 reads in flight -> all outputs return to 0 and no stale word appears after reset.
